ps2_scancode_decoder: RTL and testbench
=======================================

// Module: ps2_scancode_decoder
// PURPOSE
//  Consumes byte frames from the PS/2 receiver (done_tick / data_out / correct).
//  Strips Set-2 prefixes 0xE0 (extended), 0xF0 (break) and the 0xE1 Pause sequence.
//  Emits one key event per key action {code, ext, brk} through a small FIFO with a
//  valid/ready handshake. Sits between the PS/2 receiver and keyboard application logic.
// PARAMETERS
//  DEPTH        4          event FIFO depth, power of 2, >=2
//  TIMEOUT_CYC  2_500_000  idle cycles after a prefix before the sequence is abandoned (25 ms @100 MHz)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  rx_done_tick in   1   1-cycle pulse: new frame on rx_data/rx_start
//  rx_data      in   8   received byte (receiver data_out)
//  rx_start     in   1   received start bit (receiver correct); frame valid only if 0
//  ev_ready     in   1   consumer accepts head event this cycle
//  clr_err      in   1   clears ovf and frm_err
//  ev_valid     out  1   FIFO non-empty
//  ev_code      out  8   key code of head event (prefix bytes removed)
//  ev_ext       out  1   head event was E0-prefixed (Pause: 1)
//  ev_brk       out  1   head event is a release (F0 seen)
//  ovf          out  1   sticky: event dropped because FIFO full
//  frm_err      out  1   sticky: frame with rx_start=1 received
// BEHAVIOUR
//  Reset: FSM=S_IDLE, FIFO empty, timeout counter 0; ev_valid=0, ev_code=0, ev_ext=0,
//   ev_brk=0, ovf=0, frm_err=0.
//  A byte is consumed only on a cycle with rx_done_tick=1. A frame with rx_start=1 is
//   discarded, sets frm_err, and returns the FSM to S_IDLE.
//  FSM (on each consumed byte b):
//   S_IDLE:    E0->S_EXT; F0->S_BRK; E1->S_PAUSE (skip cnt=7); 00,AA,EE,FA,FC,FE,FF ignored;
//              else push {b,0,0}.
//   S_EXT:     F0->S_EXT_BRK; E0 ignored (stay); else push {b,1,0} ->S_IDLE.
//   S_BRK:     F0 ignored (stay); else push {b,0,1} ->S_IDLE.
//   S_EXT_BRK: push {b,1,1} ->S_IDLE.
//   S_PAUSE:   decrement skip cnt per byte; when cnt reaches 0, push {E1,1,0} ->S_IDLE.
//  Timeout: in any non-IDLE state the counter increments every cycle without
//   rx_done_tick and clears on each consumed byte. At TIMEOUT_CYC-1 the FSM goes to
//   S_IDLE and discards the partial sequence without pushing. The counter is 0 in S_IDLE.
//  Latency: push occurs on the clock edge that samples rx_done_tick. The event is visible
//   (ev_valid=1) in the next cycle if the FIFO was empty.
//  Handshake: pop when ev_valid & ev_ready. ev_code/ev_ext/ev_brk are stable while
//   ev_valid=1 and ev_ready=0. Outputs are 0 when the FIFO is empty.
//  Full: a push while full and not popping is dropped and ovf<=1.
//   Push and pop in the same cycle while full both proceed; count is unchanged and no ovf.
//  Empty: ev_ready with ev_valid=0 is ignored. Pointers wrap modulo DEPTH.
//  clr_err clears ovf/frm_err. A set condition in the same cycle as clr_err wins.
//  Reset mid-sequence or mid-FIFO: all state is lost immediately (async). No event is emitted.
// STRUCTURE
//  Shared package/header ps2_defs: state encodings S_IDLE..S_PAUSE (3 bits);
//   byte constants PFX_EXT=E0, PFX_BRK=F0, PFX_PAUSE=E1, PAUSE_SKIP=7; ignore-list codes.
//  Sub-module ps2_event_fifo (WIDTH=10, DEPTH): synchronous FIFO, rd/wr pointers
//   with one extra wrap bit, full/empty flags, and a first-word-fall-through head.
//  Top level: decoder FSM, timeout counter, skip counter, sticky flags.
// TESTING
//  1: rx 1C (start=0) -> one event {1C,ext0,brk0}, ev_valid next cycle; F0 1C -> {1C,0,1}.
//  2: E0 75, then E0 F0 75 -> {75,1,0} then {75,1,1}; an E0 E0 75 stream -> single {75,1,0}.
//  3: E1 14 77 E1 F0 14 F0 77 -> exactly one {E1,1,0}; a following 1C -> {1C,0,0}.
//  4: ev_ready=0, push DEPTH+1 makes -> first DEPTH held in order, ovf=1;
//     push+pop when full -> no ovf; clr_err -> ovf=0.
//  5: F0 then no byte for TIMEOUT_CYC cycles, then 1C -> {1C,0,0} (not a break);
//     AA/FA in S_IDLE -> no event.
//  6: frame with rx_start=1 -> no event, frm_err=1; assert rst after E0 ->
//     all outputs 0, next 75 -> {75,0,0}.

Source files
------------

// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared definitions for the PS/2 Set-2 scan-code decoder: FSM states,
// prefix byte values, the event record and the ignore-list helper.
package ps2_scancode_decoder_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_PAUSE   = 3'd4
    } ps2_state_t;

    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_BRK    = 8'hF0;
    localparam logic [7:0] PFX_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int EV_W = 10;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_event_t;

    // Keyboard status/ack bytes that never start or form a key event.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
               (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_fifo.sv
// Small synchronous event FIFO with first-word-fall-through head.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A write while full is accepted only when a read happens in the same cycle.
module ps2_scancode_decoder_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointers, wrapping naturally modulo 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (rd_ok) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: turns received bytes into key events
// {code, ext, brk} by stripping E0/F0 prefixes and the E1 Pause sequence.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   S_IDLE    | no prefix pending
//   S_EXT     | E0 seen, waiting for code or F0
//   S_BRK     | F0 seen, waiting for code
//   S_EXT_BRK | E0 F0 seen, waiting for code
//   S_PAUSE   | inside E1 Pause sequence, skipping bytes
module ps2_scancode_decoder
    import ps2_scancode_decoder_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rx_start,
    input  logic       ev_ready,
    input  logic       clr_err,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic       ovf,
    output logic       frm_err
);
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    ps2_state_t       state, state_nx;
    logic [2:0]       skip_cnt, skip_nx;
    logic [TMO_W-1:0] tmo_cnt, tmo_nx;
    logic             push;
    ps2_event_t       push_ev;
    ps2_event_t       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ovf_set;
    logic             frm_set;

    // State, skip counter and timeout counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            skip_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_nx;
            skip_cnt <= skip_nx;
            tmo_cnt  <= tmo_nx;
        end
    end

    // Next-state decode: consumed bytes advance the sequence, idle cycles age it out.
    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        tmo_nx   = tmo_cnt;
        push     = 1'b0;
        push_ev  = '0;
        if (rx_done_tick) begin
            tmo_nx = '0;
            if (rx_start) begin
                state_nx = S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (rx_data == PFX_EXT) begin
                            state_nx = S_EXT;
                        end else if (rx_data == PFX_BRK) begin
                            state_nx = S_BRK;
                        end else if (rx_data == PFX_PAUSE) begin
                            state_nx = S_PAUSE;
                            skip_nx  = PAUSE_SKIP;
                        end else if (!is_ignored(rx_data)) begin
                            push    = 1'b1;
                            push_ev = '{code: rx_data, ext: 1'b0, brk: 1'b0};
                        end
                    end
                    S_EXT: begin
                        if (rx_data == PFX_BRK) begin
                            state_nx = S_EXT_BRK;
                        end else if (rx_data != PFX_EXT) begin
                            push     = 1'b1;
                            push_ev  = '{code: rx_data, ext: 1'b1, brk: 1'b0};
                            state_nx = S_IDLE;
                        end
                    end
                    S_BRK: begin
                        if (rx_data != PFX_BRK) begin
                            push     = 1'b1;
                            push_ev  = '{code: rx_data, ext: 1'b0, brk: 1'b1};
                            state_nx = S_IDLE;
                        end
                    end
                    S_EXT_BRK: begin
                        push     = 1'b1;
                        push_ev  = '{code: rx_data, ext: 1'b1, brk: 1'b1};
                        state_nx = S_IDLE;
                    end
                    S_PAUSE: begin
                        skip_nx = skip_cnt - 3'd1;
                        if (skip_cnt == 3'd1) begin
                            push     = 1'b1;
                            push_ev  = '{code: PFX_PAUSE, ext: 1'b1, brk: 1'b0};
                            state_nx = S_IDLE;
                        end
                    end
                    default: state_nx = S_IDLE;
                endcase
            end
        end else if (state != S_IDLE) begin
            if (tmo_cnt == TMO_LAST) begin
                state_nx = S_IDLE;
                tmo_nx   = '0;
            end else begin
                tmo_nx = tmo_cnt + TMO_W'(1);
            end
        end
    end

    // A full FIFO only accepts a push when the head is leaving this cycle.
    assign ovf_set = push && fifo_full && !ev_ready;
    assign frm_set = rx_done_tick && rx_start;

    // Sticky error flags; a new error in the clearing cycle takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf     <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            if (ovf_set)      ovf <= 1'b1;
            else if (clr_err) ovf <= 1'b0;
            if (frm_set)      frm_err <= 1'b1;
            else if (clr_err) frm_err <= 1'b0;
        end
    end

    ps2_scancode_decoder_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (push_ev),
        .rd_en   (ev_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ev_valid = !fifo_empty;
    assign ev_code  = fifo_empty ? 8'h00 : head.code;
    assign ev_ext   = fifo_empty ? 1'b0  : head.ext;
    assign ev_brk   = fifo_empty ? 1'b0  : head.brk;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed steps then random byte streams,
// every cycle compared against a byte-stream reference model.
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 4;
    localparam int TC    = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_start = 1'b0;
    logic       ev_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic       ovf;
    logic       frm_err;

    int errors = 0;
    int checks = 0;

    ps2_scancode_decoder #(.DEPTH(DEPTH), .TIMEOUT_CYC(TC)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rx_start     (rx_start),
        .ev_ready     (ev_ready),
        .clr_err      (clr_err),
        .ev_valid     (ev_valid),
        .ev_code      (ev_code),
        .ev_ext       (ev_ext),
        .ev_brk       (ev_brk),
        .ovf          (ovf),
        .frm_err      (frm_err)
    );

    always #5 clk = ~clk;

    // Reference model: pending-prefix flags, queue of {code,ext,brk} events.
    logic [9:0] m_q[$];
    bit         m_ext, m_brk;
    int         m_pause_left;
    int         m_idle;
    bit         m_ovf, m_frm;

    task automatic model_clear_prefix();
        m_ext = 0; m_brk = 0; m_pause_left = 0; m_idle = 0;
    endtask

    task automatic model_reset();
        m_q.delete();
        model_clear_prefix();
        m_ovf = 0; m_frm = 0;
    endtask

    task automatic model_step();
        bit         do_push = 0;
        bit         pop;
        bit         ovf_set;
        bit         pending;
        logic [9:0] ev = '0;
        logic [9:0] dropped;
        pending = m_ext || m_brk || (m_pause_left != 0);
        if (rx_done_tick) begin
            m_idle = 0;
            if (rx_start) begin
                model_clear_prefix();
            end else if (m_pause_left != 0) begin
                m_pause_left--;
                if (m_pause_left == 0) begin do_push = 1; ev = {8'hE1, 2'b10}; end
            end else if (m_ext && m_brk) begin
                do_push = 1; ev = {rx_data, 2'b11}; model_clear_prefix();
            end else if (m_ext) begin
                if (rx_data == 8'hF0) m_brk = 1;
                else if (rx_data != 8'hE0) begin
                    do_push = 1; ev = {rx_data, 2'b10}; model_clear_prefix();
                end
            end else if (m_brk) begin
                if (rx_data != 8'hF0) begin
                    do_push = 1; ev = {rx_data, 2'b01}; model_clear_prefix();
                end
            end else begin
                if (rx_data == 8'hE0) m_ext = 1;
                else if (rx_data == 8'hF0) m_brk = 1;
                else if (rx_data == 8'hE1) m_pause_left = 7;
                else if (!(rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) begin
                    do_push = 1; ev = {rx_data, 2'b00};
                end
            end
        end else if (pending) begin
            m_idle++;
            if (m_idle >= TC) model_clear_prefix();
        end
        pop     = (m_q.size() > 0) && ev_ready;
        ovf_set = do_push && (m_q.size() == DEPTH) && !pop;
        if (pop) dropped = m_q.pop_front();
        if (do_push && !ovf_set) m_q.push_back(ev);
        if (ovf_set) m_ovf = 1; else if (clr_err) m_ovf = 0;
        if (rx_done_tick && rx_start) m_frm = 1; else if (clr_err) m_frm = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        logic [9:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 10'h000;
        chk("ev_valid", {31'd0, ev_valid}, {31'd0, m_q.size() > 0});
        chk("ev_code",  {24'd0, ev_code},  {24'd0, h[9:2]});
        chk("ev_ext",   {31'd0, ev_ext},   {31'd0, h[1]});
        chk("ev_brk",   {31'd0, ev_brk},   {31'd0, h[0]});
        chk("ovf",      {31'd0, ovf},      {31'd0, m_ovf});
        chk("frm_err",  {31'd0, frm_err},  {31'd0, m_frm});
    endtask

    // Inputs are set at the falling edge; outputs checked 1 after the rising edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic s);
        rx_done_tick = 1'b1; rx_data = b; rx_start = s;
        tick();
        rx_done_tick = 1'b0; rx_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_pop(input string tag, input logic [7:0] c, input logic e, input logic k);
        chk({tag, "_valid"}, {31'd0, ev_valid}, 32'd1);
        chk({tag, "_code"},  {24'd0, ev_code},  {24'd0, c});
        chk({tag, "_ext"},   {31'd0, ev_ext},   {31'd0, e});
        chk({tag, "_brk"},   {31'd0, ev_brk},   {31'd0, k});
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_valid", {31'd0, ev_valid}, 32'd0);
        chk("reset_code",  {24'd0, ev_code},  32'd0);
        chk("reset_ovf",   {31'd0, ovf},      32'd0);
        chk("reset_frm",   {31'd0, frm_err},  32'd0);

        // plain make, then break
        send(8'h1C, 1'b0);
        expect_pop("make_1c", 8'h1C, 1'b0, 1'b0);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        expect_pop("break_1c", 8'h1C, 1'b0, 1'b1);

        // extended make/break and repeated E0
        send(8'hE0, 1'b0); send(8'h75, 1'b0);
        expect_pop("ext_make", 8'h75, 1'b1, 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
        expect_pop("ext_break", 8'h75, 1'b1, 1'b1);
        send(8'hE0, 1'b0); send(8'hE0, 1'b0); send(8'h75, 1'b0);
        expect_pop("ext_e0e0", 8'h75, 1'b1, 1'b0);
        chk("ext_single_event", {31'd0, ev_valid}, 32'd0);

        // Pause sequence yields a single event
        send(8'hE1, 1'b0); send(8'h14, 1'b0); send(8'h77, 1'b0); send(8'hE1, 1'b0);
        send(8'hF0, 1'b0); send(8'h14, 1'b0); send(8'hF0, 1'b0); send(8'h77, 1'b0);
        expect_pop("pause", 8'hE1, 1'b1, 1'b0);
        chk("pause_single_event", {31'd0, ev_valid}, 32'd0);
        send(8'h1C, 1'b0);
        expect_pop("after_pause", 8'h1C, 1'b0, 1'b0);

        // overflow: DEPTH+1 makes with consumer stalled
        for (int i = 0; i <= DEPTH; i++) send(8'(8'h10 + i), 1'b0);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("ovf_cleared", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < DEPTH; i++) expect_pop("fifo_order", 8'(8'h10 + i), 1'b0, 1'b0);
        chk("fifo_drained", {31'd0, ev_valid}, 32'd0);

        // push and pop together while full
        for (int i = 0; i < DEPTH; i++) send(8'(8'h20 + i), 1'b0);
        ev_ready = 1'b1; send(8'h30, 1'b0); ev_ready = 1'b0;
        chk("full_push_pop_no_ovf", {31'd0, ovf}, 32'd0);
        for (int i = 1; i < DEPTH; i++) expect_pop("full_pp", 8'(8'h20 + i), 1'b0, 1'b0);
        expect_pop("full_pp_new", 8'h30, 1'b0, 1'b0);

        // overflow in the same cycle as clr_err: set wins
        for (int i = 0; i < DEPTH; i++) send(8'(8'h40 + i), 1'b0);
        clr_err = 1'b1; send(8'h50, 1'b0); clr_err = 1'b0;
        chk("ovf_set_beats_clr", {31'd0, ovf}, 32'd1);
        for (int i = 0; i < DEPTH; i++) expect_pop("drain2", 8'(8'h40 + i), 1'b0, 1'b0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;

        // timeout boundary
        send(8'hF0, 1'b0); idle(TC); send(8'h1C, 1'b0);
        expect_pop("timeout_expired", 8'h1C, 1'b0, 1'b0);
        send(8'hF0, 1'b0); idle(TC - 2); send(8'h1C, 1'b0);
        expect_pop("timeout_not_yet", 8'h1C, 1'b0, 1'b1);
        send(8'hAA, 1'b0); send(8'hFA, 1'b0);
        chk("ignored_bytes", {31'd0, ev_valid}, 32'd0);

        // framing error
        send(8'h55, 1'b1);
        chk("frm_err_set", {31'd0, frm_err}, 32'd1);
        chk("frm_no_event", {31'd0, ev_valid}, 32'd0);
        send(8'hE0, 1'b0); send(8'h12, 1'b1); send(8'h75, 1'b0);
        expect_pop("frm_resets_seq", 8'h75, 1'b0, 1'b0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("frm_cleared", {31'd0, frm_err}, 32'd0);

        // async reset mid-sequence with a queued event
        send(8'h33, 1'b0); send(8'hE0, 1'b0);
        rst = 1'b1; #1;
        model_reset();
        chk("rst_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_code",  {24'd0, ev_code},  32'd0);
        chk("rst_ext",   {31'd0, ev_ext},   32'd0);
        chk("rst_brk",   {31'd0, ev_brk},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h75, 1'b0);
        expect_pop("after_rst", 8'h75, 1'b0, 1'b0);

        // random byte streams against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            ev_ready = ($urandom_range(0, 2) != 0);
            clr_err  = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 9);
                rx_done_tick = 1'b1;
                rx_start     = ($urandom_range(0, 30) == 0);
                case (r)
                    0: rx_data = 8'hE0;
                    1: rx_data = 8'hF0;
                    2: rx_data = 8'hE1;
                    3: rx_data = 8'hAA;
                    4: rx_data = 8'hFA;
                    default: rx_data = 8'($urandom_range(0, 255));
                endcase
            end
            tick();
            rx_done_tick = 1'b0; rx_start = 1'b0; clr_err = 1'b0;
            if ($urandom_range(0, 150) == 0) begin
                ev_ready = 1'b0;
                idle($urandom_range(TC - 3, TC + 3));
            end
        end
        ev_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
